// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: multiply/divide opcodes and the muldiv sequencer states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one bit per cycle on
// sign-stripped magnitudes, signs restored in a final FIX cycle.
module ex_muldiv
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic              flush,
    input  logic              wen_hi,
    input  logic              wen_lo,
    input  logic [WORD_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi_out,
    output logic [WORD_W-1:0] lo_out
);

    localparam int CNT_W = $clog2(WORD_W);

    muldiv_state_t       r_state;
    muldiv_op_t          r_op;
    logic [WORD_W-1:0]   r_a;      // multiplicand / divisor magnitude
    logic [WORD_W-1:0]   r_b;      // multiplier / dividend magnitude (raw rs on divide-by-zero)
    logic [2*WORD_W-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sign_q;
    logic                r_sign_r;
    logic                r_div0;
    logic                r_done;
    logic [WORD_W-1:0]   r_hi;
    logic [WORD_W-1:0]   r_lo;

    logic                w_neg1;
    logic                w_neg2;
    logic [WORD_W-1:0]   w_mag1;
    logic [WORD_W-1:0]   w_mag2;
    logic                w_div_zero;
    logic                w_is_div;
    logic [WORD_W:0]     w_lhs;
    logic [WORD_W:0]     w_rhs;
    logic                w_sub;
    logic [WORD_W:0]     w_sum;
    logic [WORD_W-1:0]   w_rem_next;
    logic                w_qbit;
    logic [2*WORD_W-1:0] w_prod;
    logic [WORD_W-1:0]   w_quo;
    logic [WORD_W-1:0]   w_rem;

    assign w_neg1     = is_signed_op(op) && rdat1[WORD_W-1];
    assign w_neg2     = is_signed_op(op) && rdat2[WORD_W-1];
    assign w_mag1     = w_neg1 ? (~rdat1 + 1'b1) : rdat1;
    assign w_mag2     = w_neg2 ? (~rdat2 + 1'b1) : rdat2;
    assign w_div_zero = is_div_op(op) && (rdat2 == '0);
    assign w_is_div   = is_div_op(r_op);

    // One shared WORD_W+1 adder: add-if-bit for multiply, trial subtract for divide.
    always_comb begin
        w_lhs = '0;
        w_rhs = '0;
        w_sub = 1'b0;
        if (w_is_div) begin
            w_lhs = {r_acc[2*WORD_W-1:WORD_W], r_b[WORD_W-1]};
            w_rhs = {1'b0, r_a};
            w_sub = 1'b1;
        end else begin
            w_lhs = {1'b0, r_acc[2*WORD_W-1:WORD_W]};
            w_rhs = r_b[0] ? {1'b0, r_a} : '0;
        end
    end

    assign w_sum      = w_lhs + (w_sub ? ~w_rhs : w_rhs) + {{WORD_W{1'b0}}, w_sub};
    assign w_qbit     = ~w_sum[WORD_W];
    assign w_rem_next = w_qbit ? w_sum[WORD_W-1:0] : w_lhs[WORD_W-1:0];

    assign w_prod = r_sign_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_sign_q ? (~r_acc[WORD_W-1:0] + 1'b1) : r_acc[WORD_W-1:0];
    assign w_rem  = r_sign_r ? (~r_acc[2*WORD_W-1:WORD_W] + 1'b1) : r_acc[2*WORD_W-1:WORD_W];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_op     <= MULT;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wen_hi) r_hi <= wdat;
                    if (wen_lo) r_lo <= wdat;
                    if (start && !flush) begin
                        r_op     <= op;
                        r_a      <= w_mag2;
                        r_b      <= w_div_zero ? rdat1 : w_mag1;
                        r_sign_q <= w_neg1 ^ w_neg2;
                        r_sign_r <= w_neg1;
                        r_div0   <= w_div_zero;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        if (w_is_div) begin
                            r_acc <= {w_rem_next, r_acc[WORD_W-2:0], w_qbit};
                            if (!r_div0) r_b <= {r_b[WORD_W-2:0], 1'b0};
                        end else begin
                            r_acc <= {w_sum, r_acc[WORD_W-1:1]};
                            r_b   <= {1'b0, r_b[WORD_W-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WORD_W - 1)) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (!w_is_div) begin
                            r_hi <= w_prod[2*WORD_W-1:WORD_W];
                            r_lo <= w_prod[WORD_W-1:0];
                        end else if (r_div0) begin
                            r_hi <= r_b;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline register with the two register operands and a one-cycle start strobe. It computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over a fixed multi-cycle latency. While computing it drives `busy`, which the hazard unit uses to stall the pipeline. It also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO combinationally.

## Interface
- `WORD_W`, 32: operand and HI/LO width. The iteration count equals `WORD_W`.

- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: launch an operation; from the ID/EX control outputs.
- `op` in 2: a `muldiv_op_t` value. MULT=0, MULTU=1, DIV=2, DIVU=3.
- `rdat1` in WORD_W: rs operand (multiplicand or dividend).
- `rdat2` in WORD_W: rt operand (multiplier or divisor).
- `flush` in 1: abort any in-flight operation (branch/exception squash).
- `wen_hi` in 1: MTHI write enable.
- `wen_lo` in 1: MTLO write enable.
- `wdat` in WORD_W: MTHI/MTLO data.
- `busy` out 1: an operation is in flight; stalls the pipeline.
- `done` out 1: one-cycle pulse; HI/LO hold a new result.
- `hi_out` out WORD_W: architectural HI.
- `lo_out` out WORD_W: architectural LO.

## Operation
- States are `IDLE`, `RUN` and `FIX`. `busy` = (state != IDLE).
- `IDLE` + `start` + !`flush`:
  - Latch `op`.
  - Latch absolute values of the operands for signed ops; raw values for unsigned ops.
  - Record the result signs: product/quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Clear the iteration counter and the 2·WORD_W accumulator, then go to `RUN`.
- `RUN` performs one iteration per cycle.
  - Multiply: radix-2 shift-add on the unsigned magnitudes.
  - Divide: restoring shift-subtract; the quotient bit is set when the trial subtraction is non-negative.
  - After iteration WORD_W-1 go to `FIX`.
- `FIX`:
  - Apply the recorded signs using two's-complement negation: the full 2·WORD_W product; the quotient and remainder independently.
  - Write HI/LO. Multiply: HI = upper word, LO = lower word. Divide: LO = quotient, HI = remainder.
  - Assert `done` for the following cycle and return to `IDLE`.
- Divide by zero is detected at launch. The full latency still elapses, then LO = all ones and HI = the raw rs value, with no sign fix.
- Signed overflow 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0. This falls out of the WORD_W-bit wrap and needs no special case.
- `start` while `busy` is ignored.
- `flush` in any state forces `IDLE` next cycle. HI/LO are unchanged and `done` is not asserted. `flush` and `start` in the same cycle: `flush` wins.
- MTHI/MTLO writes:
  - Taken only in `IDLE` and ignored while `busy`.
  - A write coincident with `start` is applied, and is later overwritten by the result.
  - `wen_hi` and `wen_lo` together write both registers.
- `hi_out`/`lo_out` are the registers themselves. There is no bypass of in-flight or same-cycle write data.

## Timing
- Reset: state `IDLE`, `busy` = 0, `done` = 0, HI = 0, LO = 0, counter and accumulator = 0.
- Launch edge E0 (`start` sampled). `busy` is high from E0 through E33, i.e. 33 cycles. Edges E1..E32 are the WORD_W iterations; E33 is the `FIX` edge.
- HI/LO update at E33. `done` is high in the cycle after E33 only. A new `start` is accepted at E34.
- `RST` mid-operation: identical to power-on reset at that edge; the partial result is discarded.
- MTHI/MTLO data is visible on `hi_out`/`lo_out` the cycle after the write edge.

## Structure
- `cpu_types_pkg` gains `muldiv_op_t` (2-bit enum) and `muldiv_state_t` (IDLE/RUN/FIX); the stall logic also uses `muldiv_op_t`.
- Single module with no sub-module. Multiply and divide share the accumulator, the counter and one WORD_W+1-bit adder/subtractor.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles HI = 0xFFFFFFFE, LO = 0x00000001, one-cycle `done`.
- MULT 0xFFFFFFFD (−3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB (−21).
- DIV −7 / 2 -> LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 100 / 7 -> LO = 14, HI = 2.
- Edge cases:
  - DIV 0x80000000 / −1 -> LO = 0x80000000, HI = 0.
  - DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5.
- Flush and reset:
  - MULTU 3 × 4 with HI = LO = 0x11 preloaded; `flush` at E10 -> `busy` low at E11, HI = LO = 0x11, no `done`.
  - `RST` at E20 -> HI = LO = 0.
- HI/LO writes and start collisions:
  - MTLO 0xABCD in IDLE -> `lo_out` = 0xABCD next cycle.
  - MTHI while busy -> HI unchanged.
  - Second `start` at E5 -> ignored; the first result completes at E33.
